// File: rtl/wishbone_peripheral_to_axi.sv
// Wishbone B4 classic write-only slave feeding an AXI4-Stream-style source through a FIFO.
// Optional: define WB_TO_AXI_OVERFLOW_ERR_EN to error writes to a full FIFO instead of stalling them.
module wishbone_peripheral_to_axi #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                              in_clock,
  input  logic                              in_reset,
  input  logic                              in_wb_cyc,
  input  logic                              in_wb_stb,
  input  logic                              in_wb_we,
  input  logic [DATA_WIDTH/8-1:0]           in_wb_sel,
  input  logic [DATA_WIDTH-1:0]             in_wb_dat,
  output logic                              out_wb_ack,
  output logic                              out_wb_err,
  output logic                              out_source_valid,
  input  logic                              in_source_ready,
  output logic [DATA_WIDTH-1:0]             out_source_data,
  output logic [$clog2(FIFO_DEPTH):0]       out_fifo_level
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  generate
    if ((DATA_WIDTH == 0) || ((DATA_WIDTH % 8) != 0)) begin : g_bad_width
      $error("wishbone_peripheral_to_axi: DATA_WIDTH must be a non-zero multiple of 8");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("wishbone_peripheral_to_axi: FIFO_DEPTH must be a power of 2 and >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_ERR  = 2'd2,
    ST_WAIT = 2'd3
  } state_t;

  state_t state, state_next;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [LVL_W-1:0]      level;
  logic                  full, empty;
  logic                  push, pop;
  logic                  request, write_ok;
  logic                  ack_q, err_q;

  assign empty    = (level == '0);
  assign full     = (level == LVL_W'(FIFO_DEPTH));
  assign request  = in_wb_cyc & in_wb_stb;
  assign write_ok = in_wb_we & (&in_wb_sel);
  assign pop      = ~empty & in_source_ready;

  always_comb begin
    state_next = state;
    push       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (request) begin
          if (!write_ok) begin
            state_next = ST_ERR;
          end else if (!full) begin
            push       = 1'b1;
            state_next = ST_ACK;
          end else begin
`ifdef WB_TO_AXI_OVERFLOW_ERR_EN
            state_next = ST_ERR;
`else
            state_next = ST_WAIT;
`endif
          end
        end
      end
      ST_ACK:  state_next = ST_IDLE;
      ST_ERR:  state_next = ST_IDLE;
      ST_WAIT: begin
        // Master abandoning the cycle releases the stall without pushing.
        if (!in_wb_cyc) begin
          state_next = ST_IDLE;
        end else if (!full) begin
          push       = 1'b1;
          state_next = ST_ACK;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      state <= ST_IDLE;
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_next;
      ack_q <= (state_next == ST_ACK);
      err_q <= (state_next == ST_ERR);
    end
  end

  always_ff @(posedge in_clock) begin
    if (push) begin
      mem[wr_ptr] <= in_wb_dat;
    end
  end

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  assign out_wb_ack       = ack_q;
  assign out_wb_err       = err_q;
  assign out_source_valid = ~empty;
  assign out_source_data  = empty ? '0 : mem[rd_ptr];
  assign out_fifo_level   = level;

endmodule

// File: tb/tb_wishbone_peripheral_to_axi.sv
// Directed self-checking bench for wishbone_peripheral_to_axi (DATA_WIDTH=16, FIFO_DEPTH=4).
module tb_wishbone_peripheral_to_axi;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [1:0]  sel;
  logic [15:0] dat;
  logic        ack, err, valid, ready;
  logic [15:0] sdata;
  logic [2:0]  level;

  int unsigned tests = 0;
  int unsigned fails = 0;

  wishbone_peripheral_to_axi #(
    .DATA_WIDTH(16),
    .FIFO_DEPTH(4)
  ) dut (
    .in_clock        (clk),
    .in_reset        (rst),
    .in_wb_cyc       (cyc),
    .in_wb_stb       (stb),
    .in_wb_we        (we),
    .in_wb_sel       (sel),
    .in_wb_dat       (dat),
    .out_wb_ack      (ack),
    .out_wb_err      (err),
    .out_source_valid(valid),
    .in_source_ready (ready),
    .out_source_data (sdata),
    .out_fifo_level  (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_req(input logic [15:0] d, input logic w, input logic [1:0] s);
    cyc = 1'b1; stb = 1'b1; we = w; sel = s; dat = d;
  endtask

  task automatic bus_idle();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 2'b00; dat = '0;
  endtask

  task automatic push_ok(input logic [15:0] d, input string tag);
    bus_req(d, 1'b1, 2'b11);
    tick();
    check({tag, "_ack"}, {31'd0, ack}, 32'd1);
    check({tag, "_noerr"}, {31'd0, err}, 32'd0);
    bus_idle();
    tick();
    check({tag, "_ack_low"}, {31'd0, ack}, 32'd0);
  endtask

  // Expects ready=1; checks the head then lets it pop at the next edge.
  task automatic head(input logic [15:0] exp, input string tag);
    check({tag, "_valid"}, {31'd0, valid}, 32'd1);
    check({tag, "_data"}, {16'd0, sdata}, {16'd0, exp});
    tick();
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_valid0"}, {31'd0, valid}, 32'd0);
    check({tag, "_level0"}, {29'd0, level}, 32'd0);
    check({tag, "_data0"}, {16'd0, sdata}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; ready = 1'b0;
    bus_idle();
    tick();
    tick();
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check_empty("rst");
    rst = 1'b0;

    // 1: single write, consumer ready
    ready = 1'b1;
    tick();
    check_empty("t1_empty_ready");
    bus_req(16'h00A5, 1'b1, 2'b11);
    tick();
    check("t1_ack", {31'd0, ack}, 32'd1);
    check("t1_err", {31'd0, err}, 32'd0);
    check("t1_valid", {31'd0, valid}, 32'd1);
    check("t1_data", {16'd0, sdata}, 32'h00A5);
    check("t1_level", {29'd0, level}, 32'd1);
    bus_idle();
    tick();
    check("t1_ack_low", {31'd0, ack}, 32'd0);
    check_empty("t1_popped");

    // 2: read and partial-select write both error
    bus_req(16'h1234, 1'b0, 2'b11);
    tick();
    check("t2_rd_err", {31'd0, err}, 32'd1);
    check("t2_rd_ack", {31'd0, ack}, 32'd0);
    check("t2_rd_level", {29'd0, level}, 32'd0);
    bus_idle();
    tick();
    check("t2_rd_err_low", {31'd0, err}, 32'd0);
    bus_req(16'h5678, 1'b1, 2'b01);
    tick();
    check("t2_sel_err", {31'd0, err}, 32'd1);
    check("t2_sel_ack", {31'd0, ack}, 32'd0);
    check("t2_sel_level", {29'd0, level}, 32'd0);
    bus_idle();
    tick();
    check("t2_sel_err_low", {31'd0, err}, 32'd0);
    check("t2_valid", {31'd0, valid}, 32'd0);

    // 3: fill, then write to a full FIFO
    ready = 1'b0;
    push_ok(16'h0001, "t3_w1");
    push_ok(16'h0002, "t3_w2");
    push_ok(16'h0003, "t3_w3");
    push_ok(16'h0004, "t3_w4");
    check("t3_full_level", {29'd0, level}, 32'd4);
    check("t3_full_head", {16'd0, sdata}, 32'h0001);
    bus_req(16'h0005, 1'b1, 2'b11);
    tick();
`ifdef WB_TO_AXI_OVERFLOW_ERR_EN
    check("t3_ovf_err", {31'd0, err}, 32'd1);
    check("t3_ovf_ack", {31'd0, ack}, 32'd0);
    check("t3_ovf_level", {29'd0, level}, 32'd4);
    bus_idle();
    tick();
    check("t3_ovf_err_low", {31'd0, err}, 32'd0);
    ready = 1'b1;
    head(16'h0001, "t3_h1");
    head(16'h0002, "t3_h2");
    head(16'h0003, "t3_h3");
    head(16'h0004, "t3_h4");
    check_empty("t3_drained");
`else
    check("t3_wait_ack", {31'd0, ack}, 32'd0);
    check("t3_wait_err", {31'd0, err}, 32'd0);
    check("t3_wait_level", {29'd0, level}, 32'd4);
    tick();
    check("t3_wait_ack2", {31'd0, ack}, 32'd0);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("t3_pop_level", {29'd0, level}, 32'd3);
    check("t3_pop_ack", {31'd0, ack}, 32'd0);
    check("t3_pop_head", {16'd0, sdata}, 32'h0002);
    tick();
    check("t3_late_ack", {31'd0, ack}, 32'd1);
    check("t3_late_level", {29'd0, level}, 32'd4);
    bus_idle();
    tick();
    check("t3_late_ack_low", {31'd0, ack}, 32'd0);
    ready = 1'b1;
    head(16'h0002, "t3_h2");
    head(16'h0003, "t3_h3");
    head(16'h0004, "t3_h4");
    head(16'h0005, "t3_h5");
    check_empty("t3_drained");
`endif

    // 4: simultaneous push and pop holds the level
    ready = 1'b0;
    push_ok(16'h0010, "t4_w10");
    push_ok(16'h0011, "t4_w11");
    check("t4_level2", {29'd0, level}, 32'd2);
    bus_req(16'h0012, 1'b1, 2'b11);
    ready = 1'b1;
    check("t4_head10", {16'd0, sdata}, 32'h0010);
    tick();
    check("t4_pp1_ack", {31'd0, ack}, 32'd1);
    check("t4_pp1_level", {29'd0, level}, 32'd2);
    check("t4_pp1_head", {16'd0, sdata}, 32'h0011);
    ready = 1'b0;
    bus_idle();
    tick();
    check("t4_hold_level", {29'd0, level}, 32'd2);
    bus_req(16'h0013, 1'b1, 2'b11);
    ready = 1'b1;
    tick();
    check("t4_pp2_ack", {31'd0, ack}, 32'd1);
    check("t4_pp2_level", {29'd0, level}, 32'd2);
    check("t4_pp2_head", {16'd0, sdata}, 32'h0012);
    ready = 1'b0;
    bus_idle();
    tick();
    ready = 1'b1;
    head(16'h0012, "t4_h12");
    head(16'h0013, "t4_h13");
    check_empty("t4_drained");

    // 5: reset mid-transfer with ack high
    ready = 1'b0;
    push_ok(16'h0020, "t5_w20");
    push_ok(16'h0021, "t5_w21");
    bus_req(16'h0022, 1'b1, 2'b11);
    tick();
    check("t5_pre_ack", {31'd0, ack}, 32'd1);
    check("t5_pre_level", {29'd0, level}, 32'd3);
    rst = 1'b1;
    bus_idle();
    tick();
    check("t5_ack", {31'd0, ack}, 32'd0);
    check("t5_err", {31'd0, err}, 32'd0);
    check_empty("t5");
    rst = 1'b0;
    tick();

`ifndef WB_TO_AXI_OVERFLOW_ERR_EN
    // 6: master abandons a stalled write
    push_ok(16'h0030, "t6_w30");
    push_ok(16'h0031, "t6_w31");
    push_ok(16'h0032, "t6_w32");
    push_ok(16'h0033, "t6_w33");
    bus_req(16'h0034, 1'b1, 2'b11);
    tick();
    check("t6_wait_ack", {31'd0, ack}, 32'd0);
    tick();
    bus_idle();
    tick();
    check("t6_drop_ack", {31'd0, ack}, 32'd0);
    check("t6_drop_err", {31'd0, err}, 32'd0);
    check("t6_drop_level", {29'd0, level}, 32'd4);
    check("t6_drop_head", {16'd0, sdata}, 32'h0030);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("t6_pop_level", {29'd0, level}, 32'd3);
    tick();
    check("t6_no_stale_push", {29'd0, level}, 32'd3);
    check("t6_no_stale_ack", {31'd0, ack}, 32'd0);
    push_ok(16'h0035, "t6_w35");
    ready = 1'b1;
    head(16'h0031, "t6_h31");
    head(16'h0032, "t6_h32");
    head(16'h0033, "t6_h33");
    head(16'h0035, "t6_h35");
    check_empty("t6_drained");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
